// File: rtl/led_ctrl_pkg.sv
// Shared LED controller types: channel mode encodings used by RTL,
// software and testbench.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_STRETCH = 2'd3
  } mode_t;

endpackage

// File: rtl/led_status_ctrl_if.sv
// Channel configuration write bus for led_status_ctrl.
// master drives a one-cycle cfg_we strobe, slave consumes it.
interface led_status_ctrl_if #(
  parameter int N_CH   = 8,
  parameter int HALF_W = 10
);
  import led_ctrl_pkg::*;

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  mode_t             cfg_mode;
  logic [HALF_W-1:0] cfg_half;

  modport master (
    output cfg_we, cfg_ch, cfg_mode, cfg_half
  );

  modport slave (
    input cfg_we, cfg_ch, cfg_mode, cfg_half
  );

endinterface

// File: rtl/led_evt_sync.sv
// Event input synchroniser: SYNC_STAGES flop chain plus a
// one-cycle rising-edge pulse on the synchronised level.
module led_evt_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic evt_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], evt_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/led_status_ctrl.sv
// LED bank controller: one shared tick prescaler, per-channel OFF/ON/
// BLINK/STRETCH modes. Define LED_PWM_EN to add global dim_duty PWM.
module led_status_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int N_CH          = 8,
  parameter int PRESCALE      = 100000,
  parameter int HALF_W        = 10,
  parameter int BLINK_DEF     = 500,
  parameter int STRETCH_TICKS = 50,
  parameter int SYNC_STAGES   = 2,
  parameter int PWM_BITS      = 4
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  led_status_ctrl_if.slave    cfg,
  input  logic [N_CH-1:0]     evt_in,
`ifdef LED_PWM_EN
  input  logic [PWM_BITS-1:0] dim_duty,
`endif
  output logic                tick_o,
  output logic [N_CH-1:0]     led_o
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PS_W = $clog2(PRESCALE);
  localparam int SC_W = $clog2(STRETCH_TICKS + 1);

  if (PRESCALE < 2 || SYNC_STAGES < 2 || PWM_BITS < 1)
    begin : g_bad_param
      $error("led_status_ctrl: illegal parameter set");
    end

  logic [PS_W-1:0]   psc_q, psc_d;
  logic              tick;
  logic [N_CH-1:0]   led_q, led_d;
  logic [N_CH-1:0]   phase_q, phase_d;
  logic [N_CH-1:0]   rise, raw;
  mode_t             mode_q [N_CH];
  mode_t             mode_d [N_CH];
  logic [HALF_W-1:0] half_q [N_CH];
  logic [HALF_W-1:0] half_d [N_CH];
  logic [HALF_W-1:0] cnt_q  [N_CH];
  logic [HALF_W-1:0] cnt_d  [N_CH];
  logic [SC_W-1:0]   scnt_q [N_CH];
  logic [SC_W-1:0]   scnt_d [N_CH];

  assign tick  = (psc_q == PS_W'(PRESCALE - 1));
  assign psc_d = tick ? '0 : psc_q + 1'b1;

  for (genvar g = 0; g < N_CH; g++) begin : g_sync
    led_evt_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .sys_clk(sys_clk),
      .sys_rst(sys_rst),
      .evt_i  (evt_in[g]),
      .rise_o (rise[g])
    );
  end

  // A config write clears the channel and swallows a same-cycle tick.
  always_comb begin
    phase_d = phase_q;
    raw     = '0;
    for (int i = 0; i < N_CH; i++) begin
      mode_d[i] = mode_q[i];
      half_d[i] = half_q[i];
      cnt_d[i]  = cnt_q[i];
      scnt_d[i] = scnt_q[i];
      if (cfg.cfg_we && cfg.cfg_ch == CH_W'(i)) begin
        mode_d[i]  = cfg.cfg_mode;
        half_d[i]  = (cfg.cfg_half == '0) ?
                     HALF_W'(1) : cfg.cfg_half;
        cnt_d[i]   = '0;
        phase_d[i] = 1'b0;
        scnt_d[i]  = '0;
      end else if (mode_q[i] == MODE_BLINK) begin
        if (tick) begin
          if (cnt_q[i] == half_q[i] - 1'b1) begin
            cnt_d[i]   = '0;
            phase_d[i] = ~phase_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
      end else if (mode_q[i] == MODE_STRETCH) begin
        if (rise[i])
          scnt_d[i] = SC_W'(STRETCH_TICKS);
        else if (tick && scnt_q[i] != '0)
          scnt_d[i] = scnt_q[i] - 1'b1;
      end
      unique case (mode_q[i])
        MODE_ON:      raw[i] = 1'b1;
        MODE_BLINK:   raw[i] = phase_q[i];
        MODE_STRETCH: raw[i] = (scnt_q[i] != '0);
        default:      raw[i] = 1'b0;
      endcase
    end
  end

`ifdef LED_PWM_EN
  logic [PWM_BITS-1:0] pcnt_q;
  logic                lit;

  assign lit   = (pcnt_q < dim_duty);
  assign led_d = raw & {N_CH{lit}};

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)
      pcnt_q <= '0;
    else
      pcnt_q <= pcnt_q + 1'b1;
  end
`else
  assign led_d = raw;
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      psc_q   <= '0;
      led_q   <= '0;
      phase_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        mode_q[i] <= MODE_OFF;
        half_q[i] <= HALF_W'(BLINK_DEF);
        cnt_q[i]  <= '0;
        scnt_q[i] <= '0;
      end
    end else begin
      psc_q   <= psc_d;
      led_q   <= led_d;
      phase_q <= phase_d;
      mode_q  <= mode_d;
      half_q  <= half_d;
      cnt_q   <= cnt_d;
      scnt_q  <= scnt_d;
    end
  end

  assign tick_o = tick;
  assign led_o  = led_q;

endmodule
